// File: rtl/motorpasso_onchip_ram_dp_if.sv
// Avalon-MM slave port bundle for motorpasso_onchip_ram_dp. Use one instance per port.
// Build option MOTORPASSO_ONCHIP_RAM_PARITY_EN adds the sticky parity_err response.
interface motorpasso_onchip_ram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
    logic                parity_err;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest, parity_err
    );
    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest, parity_err
    );
`else
    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );
    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
`endif
endinterface

// File: rtl/motorpasso_onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM that serves as shared step-profile storage.
// s1 and s2 share one array. Reads are pipelined (READ_LATENCY 1 or 2) and return old
// data on read-during-write. When both ports write the same word, s1 wins and s2 is
// stalled for one cycle. Addresses >= DEPTH read as 0 and drop writes.
// clken=0 or reset_req=1 freezes the whole block.
// Optional build: MOTORPASSO_ONCHIP_RAM_PARITY_EN stores even parity per byte and
// raises a sticky per-port parity error flag.
module motorpasso_onchip_ram_dp #(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 15,
    parameter int    DEPTH        = 32768,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "MotorPasso_onchip_ram_dp.hex"
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    input  logic reset_req,
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
    input  logic parity_inject,
`endif
    motorpasso_onchip_ram_dp_if.slave s1,
    motorpasso_onchip_ram_dp_if.slave s2
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT   = (READ_LATENCY >= 2) ? 2 : 1;

    // The vendor flow preloads the array from INIT_FILE.
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
    logic [NB-1:0]     par_mem [DEPTH];
    logic [1:0]        perr;
`endif

    logic              freeze;
    logic              collide;
    logic [ADDR_W-1:0] addr  [2];
    logic [IDX_W-1:0]  idx   [2];
    logic [NB-1:0]     be    [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] rdata [2];
    logic [1:0]        cs, rd, wr, in_range, wait_req, acc, wr_acc, rd_acc, rvalid;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign cs       = {s2.chipselect, s1.chipselect};
    assign rd       = {s2.read, s1.read};
    assign wr       = {s2.write, s1.write};
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;

    assign freeze  = ~clken | reset_req;
    assign collide = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);

    // waitrequest is purely combinational. Only s2 yields on a write-write collision.
    assign wait_req[0] = reset | freeze;
    assign wait_req[1] = reset | freeze | collide;

    assign s1.waitrequest   = wait_req[0];
    assign s2.waitrequest   = wait_req[1];
    assign s1.readdata      = rdata[0];
    assign s2.readdata      = rdata[1];
    assign s1.readdatavalid = rvalid[0];
    assign s2.readdatavalid = rvalid[1];
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
    assign s1.parity_err    = perr[0];
    assign s2.parity_err    = perr[1];

    function automatic logic [NB-1:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^d[b*8 +: 8];
        return p;
    endfunction
`endif

    // Write into the shared array. The collision stall keeps the two ports off the same word.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (wr_acc[p] && in_range[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[p][b]) begin
                        mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
                        par_mem[idx[p]][b] <= (^wdata[p][b*8 +: 8]) ^ parity_inject;
`endif
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [LAT-1:0][DATA_W-1:0] data_reg;
            logic [LAT-1:0]             vld_reg;
            logic [LAT-1:0]             ok_reg;
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
            logic [LAT-1:0][NB-1:0]     par_reg;
            logic                       perr_reg;
`endif

            assign idx[gi]      = addr[gi][IDX_W-1:0];
            assign in_range[gi] = ({1'b0, addr[gi]} < (ADDR_W+1)'(DEPTH));
            assign acc[gi]      = cs[gi] & (rd[gi] | wr[gi]) & ~wait_req[gi];
            assign wr_acc[gi]   = acc[gi] & wr[gi];
            assign rd_acc[gi]   = acc[gi] & rd[gi] & ~wr[gi];

            // Read pipeline. It advances on every unfrozen edge and holds its contents during a freeze.
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                    vld_reg  <= '0;
                    ok_reg   <= '0;
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
                    par_reg  <= '0;
`endif
                end else if (!freeze) begin
                    data_reg[0] <= mem[idx[gi]];
                    vld_reg[0]  <= rd_acc[gi];
                    ok_reg[0]   <= in_range[gi];
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
                    par_reg[0]  <= par_mem[idx[gi]];
`endif
                    for (int i = 1; i < LAT; i++) begin
                        data_reg[i] <= data_reg[i-1];
                        vld_reg[i]  <= vld_reg[i-1];
                        ok_reg[i]   <= ok_reg[i-1];
`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
                        par_reg[i]  <= par_reg[i-1];
`endif
                    end
                end
            end

            // Out-of-range reads are zeroed after the array register, so the RAM output stays unmuxed.
            assign rdata[gi]  = ok_reg[LAT-1] ? data_reg[LAT-1] : '0;
            assign rvalid[gi] = vld_reg[LAT-1] & ~freeze & ~reset;

`ifdef MOTORPASSO_ONCHIP_RAM_PARITY_EN
            // Sticky error when a valid in-range response carries a stored parity that disagrees.
            always_ff @(posedge clk) begin
                if (reset) begin
                    perr_reg <= 1'b0;
                end else if (rvalid[gi] && ok_reg[LAT-1] &&
                             (lane_parity(data_reg[LAT-1]) != par_reg[LAT-1])) begin
                    perr_reg <= 1'b1;
                end
            end
            assign perr[gi] = perr_reg;
`endif
        end
    endgenerate
endmodule

// File: doc/motorpasso_onchip_ram_dp.md
# motorpasso_onchip_ram_dp

Parametrised dual-port Avalon-MM on-chip RAM, the successor to the single-port 32K×32 on-chip memory in the MotorPasso Qsys system. It has two independent slave ports (s1, s2) on a shared array, with configurable data width, depth and read latency (1 or 2 cycles). It generates `readdatavalid`, and it resolves same-address write collisions with `waitrequest`. It sits between the Nios II data master (s1) and the motor-step DMA/peripheral master (s2) as shared step-profile storage.

## Interface
Parameters:
- `DATA_W`, 32: data width; multiple of 8, range 8..128.
- `ADDR_W`, 15: word-address width.
- `DEPTH`, 32768: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- `READ_LATENCY`, 1: cycles from read acceptance to `readdatavalid`; legal values 1 or 2.
- `INIT_FILE`, "MotorPasso_onchip_ram_dp.hex": simulation and synthesis initial contents.

Ports (sx = s1 and s2, identical sets):
- `clk` in 1: single clock.
- `reset` in 1: synchronous reset, active-high.
- `clken` in 1: global clock enable; 0 freezes the block.
- `reset_req` in 1: reset-request hold; 1 freezes the block.
- `sx_address` in ADDR_W: word address.
- `sx_chipselect` in 1: port select.
- `sx_read` in 1: read request.
- `sx_write` in 1: write request.
- `sx_byteenable` in DATA_W/8: write byte lanes.
- `sx_writedata` in DATA_W: write data.
- `sx_readdata` out DATA_W: read data.
- `sx_readdatavalid` out 1: `sx_readdata` is valid this cycle.
- `sx_waitrequest` out 1: request not accepted this cycle.
- `parity_inject` in 1 (parity build only): writes store inverted parity.
- `sx_parity_err` out 1 (parity build only): sticky parity error flag.

## Operation
- **Acceptance.** A request on port x is accepted on a rising edge when `sx_chipselect & (sx_read | sx_write) & ~sx_waitrequest`. A request with read and write both set is illegal; the write takes priority and no read response is generated.
- **Writes.** An accepted write updates only the byte lanes enabled in `sx_byteenable`. A write with all byte lanes 0 is accepted but changes nothing.
- **Reads.** An accepted read returns the array word through a READ_LATENCY-stage pipeline. Reads are fully pipelined, so one read per cycle per port is allowed.
- **Read-during-write.** A read on either port to an address written in the same cycle returns the old data. Both the same-port and cross-port cases behave this way.
- **Collision.** When both ports present writes to the same address in the same cycle:
  - s1 is accepted.
  - `s2_waitrequest` is 1 for that cycle.
  - s2 is accepted on the next cycle if it is still presented, so the final contents equal s2's write.
  - Collisions between a write on one port and a read on the other never stall.
- **Out of range.** An address ≥ DEPTH is accepted. A write to it is discarded. A read from it returns 0 with normal `readdatavalid` timing.
- **Freeze** (`clken`=0 or `reset_req`=1):
  - Both `waitrequest` outputs are 1.
  - No array update occurs.
  - The read pipeline holds its state, and `readdatavalid` is forced to 0.
  - Pending responses emerge in order after the freeze ends.
- **Reset.**
  - Clears the read pipeline, so reads in flight are dropped.
  - Sets `readdata`=0, `readdatavalid`=0 and `parity_err`=0.
  - `waitrequest` is 1 during reset and 0 in the first cycle after reset, unless a freeze or collision holds it.
  - Array contents are not cleared.

## Timing
- A read accepted at edge T sets `readdatavalid`=1 for exactly one cycle after edge T+READ_LATENCY-1. For READ_LATENCY=1 this is the cycle following T; each additional stage adds one cycle.
- A write accepted at edge T is visible to any read accepted at edge T+1.
- `waitrequest` is combinational from the request inputs, `clken`, `reset_req` and `reset`. It has no other state.
- Response ordering per port is strictly FIFO; there is no cross-port ordering.

## Configuration
- Macro: `MOTORPASSO_ONCHIP_RAM_PARITY_EN`.
- **Defined:**
  - The array stores one even-parity bit per byte.
  - Each write computes parity for its enabled lanes, inverted when `parity_inject`=1.
  - Each read checks parity for all lanes as the word leaves the pipeline.
  - A mismatch on a valid read sets `sx_parity_err` until reset. `sx_readdata` is returned unchanged.
  - An out-of-range read never flags an error.
- **Undefined:** there is no parity storage, and the `parity_inject` and `sx_parity_err` ports are absent.

## Test plan
- Write 0xDEADBEEF to s1 address 5, then read s1 address 5 with READ_LATENCY=2 -> `readdatavalid` two cycles after acceptance with 0xDEADBEEF.
- s1 writes 0x11223344 to address 9 and s2 writes 0xAABBCCDD to address 9 in the same cycle -> `s2_waitrequest`=1 for one cycle; a read of address 9 afterwards returns 0xAABBCCDD.
- s1 writes 0x000000FF to address 3 holding 0x12345678 while s2 reads address 3 in the same cycle -> s2 gets 0x12345678; the next read returns 0x123456FF.
- Issue back-to-back reads of addresses 0..3, drop `clken` for 3 cycles mid-stream -> all four responses arrive in order, `readdatavalid` stays 0 during the freeze, and no response is lost.
- Read address DEPTH (DEPTH=1000) -> `readdata`=0 and `readdatavalid` asserted; a write there leaves address 0 unchanged.
- Parity build: write with `parity_inject`=1 to address 7, then read address 7 -> `s1_parity_err`=1 and it stays set; `reset` clears it.
